dm_arbiter: RTL and testbench

- Sequences every access to the single-ported data memory.
- Shares the memory between two requesters: the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- Generates byte enables, replicated write data and load extraction (sign- or zero-extended).
- Stalls the pipeline until the CPU's access completes, and prevents EXT starvation.

---
 rtl/dm_arbiter_if.sv | 45 ++++
 rtl/dm_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dm_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, EXT and memory port bundle for dm_arbiter
// Ports:
//   cpu_*  : MEM-stage requester (req/we/size/sext/addr/wdata in, rdata/stall out)
//   ext_*  : loader/debug requester (req/we/addr/wdata in, ack/rdata out)
//   mem_*  : single-ported data memory (en/we/addr/wdata out, rdata in)
//   err_align : misaligned CPU access pulse
// Modports: slave = the arbiter, master = requesters plus memory.
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        err_align;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, ext_ack, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, err_align
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, ext_ack, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, err_align
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data memory sequencer shared by CPU and EXT requesters
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dm_arbiter_if.slave (CPU port, EXT port, memory port, err_align)
// Parameters:
//   LAT    : memory read latency in cycles (>=1)
//   STARVE : CPU grants EXT may lose in a row before it is forced to win
module dm_arbiter #(
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  logic [1:0]    state;
  logic          owner;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_sext;
  logic          lat_misal;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   ext_rdata_q;

  logic          pending;
  logic          ext_wins;
  logic          cpu_misal;
  logic          in_issue;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;

  assign pending  = bus.cpu_req | bus.ext_req;
  // EXT only beats a waiting CPU once it has lost STARVE grants in a row.
  assign ext_wins = bus.ext_req & (~bus.cpu_req | (starve_cnt == STARVE_MAX));
  assign in_issue = (state == ST_ISSUE);

  // Size 2'b11 falls into the word rule.
  always_comb begin
    case (bus.cpu_size)
      2'b01:   cpu_misal = bus.cpu_addr[0];
      2'b10:   cpu_misal = 1'b0;
      default: cpu_misal = |bus.cpu_addr[1:0];
    endcase
  end

  // Store lane steering; reads leave all enables low.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = lat_wdata;
    if (lat_we) begin
      case (lat_size)
        2'b01: begin
          lane_wdata = {2{lat_wdata[15:0]}};
          lane_we    = lat_addr[1] ? 4'b1100 : 4'b0011;
        end
        2'b10: begin
          lane_wdata = {4{lat_wdata[7:0]}};
          lane_we    = 4'b0001 << lat_addr[1:0];
        end
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // Little-endian load extraction; EXT transactions are latched as
  // unsigned words so they pass through untouched.
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lat_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (lat_size)
      2'b01:   load_val = lat_sext ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
      2'b10:   load_val = lat_sext ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      lat_we      <= 1'b0;
      lat_size    <= 2'b00;
      lat_sext    <= 1'b0;
      lat_misal   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (!bus.ext_req) begin
        starve_cnt <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (pending) begin
            if (ext_wins) begin
              owner      <= OWN_EXT;
              lat_we     <= bus.ext_we;
              lat_size   <= 2'b00;
              lat_sext   <= 1'b0;
              lat_misal  <= 1'b0;
              lat_addr   <= bus.ext_addr;
              lat_wdata  <= bus.ext_wdata;
              starve_cnt <= '0;
              state      <= ST_ISSUE;
            end else begin
              owner     <= OWN_CPU;
              lat_we    <= bus.cpu_we;
              lat_size  <= bus.cpu_size;
              lat_sext  <= bus.cpu_sext;
              lat_misal <= cpu_misal;
              lat_addr  <= bus.cpu_addr;
              lat_wdata <= bus.cpu_wdata;
              if (bus.ext_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
              // A misaligned access never touches memory and reads back as 0.
              if (cpu_misal) begin
                cpu_rdata_q <= '0;
                state       <= ST_RESP;
              end else begin
                state <= ST_ISSUE;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (lat_we) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= LAT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The last WAIT cycle is the one where mem_rdata is valid.
          if (wait_cnt == CW'(1)) begin
            if (owner == OWN_EXT) begin
              ext_rdata_q <= load_val;
            end else begin
              cpu_rdata_q <= load_val;
            end
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = in_issue;
  assign bus.mem_we    = in_issue ? lane_we : 4'b0000;
  assign bus.mem_addr  = in_issue ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = in_issue ? lane_wdata : 32'h0;

  assign bus.ext_ack   = (state == ST_RESP) & (owner == OWN_EXT);
  assign bus.err_align = (state == ST_RESP) & (owner == OWN_CPU) & lat_misal;

  // Gated by reset so the pipeline is released while the arbiter is held.
  assign bus.cpu_stall = reset & bus.cpu_req & ~((state == ST_RESP) & (owner == OWN_CPU));

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
module tb_dm_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic clk;
  logic reset;
  dm_arbiter_if bus ();

  dm_arbiter #(.LAT(LAT), .STARVE(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Memory device (what the DUT actually writes) and the model's own image.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int          rd_cnt;
  logic        rd_armed;
  logic [31:0] rd_word;

  // Read data is valid only during the cycle LAT cycles after the issue
  // cycle; any other cycle carries noise.
  always @(negedge clk) begin
    if (rd_cnt > 0) rd_cnt = rd_cnt - 1;
    if (rd_armed && rd_cnt == 0) begin
      bus.mem_rdata = rd_word;
      rd_armed = 1'b0;
    end else begin
      bus.mem_rdata = $urandom();
    end
    if (bus.mem_en) begin
      if (bus.mem_we == 4'b0000) begin
        rd_word  = mem[bus.mem_addr[7:2]];
        rd_cnt   = LAT;
        rd_armed = 1'b1;
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (bus.mem_we[l]) mem[bus.mem_addr[7:2]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
        end
      end
    end
  end

  task automatic cpu_op(input string tag, input logic we, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd_obs, output int lat_obs);
    int off, idx, nb, exp_lat, en_cnt, en_cyc, err_cnt;
    logic misal;
    logic [31:0] w, v, exp_wd, addr_obs, wd_obs;
    logic [3:0] exp_we, we_obs;
    off   = int'(addr % 4);
    idx   = int'((addr / 4) % 64);
    nb    = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
    misal = (off % nb) != 0;
    exp_lat = misal ? 1 : (we ? 2 : 2 + LAT);
    exp_we = 4'b0000;
    exp_wd = 32'h0;
    v      = 32'h0;
    if (!misal) begin
      for (int k = 0; k < nb; k++) exp_we[off + k] = we;
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wdata[8*(l % nb) +: 8];
      if (!we) begin
        w = ref_mem[idx];
        for (int k = 0; k < nb; k++) v[8*k +: 8] = w[8*(off + k) +: 8];
        if (sext && nb < 4 && v[8*nb - 1]) begin
          for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
      end else begin
        for (int k = 0; k < nb; k++) ref_mem[idx][8*(off + k) +: 8] = wdata[8*k +: 8];
      end
    end
    bus.cpu_we = we; bus.cpu_size = size; bus.cpu_sext = sext;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    rd_obs = 32'h0; lat_obs = -1; en_cnt = 0; en_cyc = -1; err_cnt = 0;
    addr_obs = 32'h0; wd_obs = 32'h0; we_obs = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++; en_cyc = c;
        addr_obs = bus.mem_addr; we_obs = bus.mem_we; wd_obs = bus.mem_wdata;
      end
      if (bus.err_align) err_cnt++;
      if (!bus.cpu_stall) begin
        lat_obs = c;
        rd_obs  = bus.cpu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    chk({tag, ":lat"}, lat_obs, exp_lat);
    chk({tag, ":en_cnt"}, en_cnt, misal ? 1 - 1 : 1);
    chk({tag, ":err"}, err_cnt, misal ? 1 : 0);
    if (!misal) begin
      chk({tag, ":issue_cyc"}, en_cyc, 1);
      chk({tag, ":mem_addr"}, addr_obs, addr & 32'hFFFF_FFFC);
      chk({tag, ":mem_we"}, {28'h0, we_obs}, {28'h0, exp_we});
      if (we) chk({tag, ":mem_wdata"}, wd_obs, exp_wd);
    end
    if (!we || misal) chk({tag, ":rdata"}, rd_obs, v);
  endtask

  task automatic ext_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd_obs, output int lat_obs);
    int idx, exp_lat, en_cnt;
    logic [31:0] v, addr_obs, wd_obs;
    logic [3:0] we_obs;
    idx     = int'((addr / 4) % 64);
    exp_lat = we ? 2 : 2 + LAT;
    v       = ref_mem[idx];
    if (we) ref_mem[idx] = wdata;
    bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata; bus.ext_req = 1'b1;
    rd_obs = 32'h0; lat_obs = -1; en_cnt = 0;
    addr_obs = 32'h0; wd_obs = 32'h0; we_obs = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++;
        addr_obs = bus.mem_addr; we_obs = bus.mem_we; wd_obs = bus.mem_wdata;
      end
      if (bus.ext_ack) begin
        lat_obs = c;
        rd_obs  = bus.ext_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.ext_req = 1'b0;
    chk({tag, ":lat"}, lat_obs, exp_lat);
    chk({tag, ":en_cnt"}, en_cnt, 1);
    chk({tag, ":mem_addr"}, addr_obs, addr & 32'hFFFF_FFFC);
    chk({tag, ":mem_we"}, {28'h0, we_obs}, we ? 32'hF : 32'h0);
    if (we) chk({tag, ":mem_wdata"}, wd_obs, wdata);
    else    chk({tag, ":rdata"}, rd_obs, v);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    n_cmp = 0; n_bad = 0;
    rd_cnt = 0; rd_armed = 1'b0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[4]  = 32'h80817F01; ref_mem[4]  = 32'h80817F01;
    mem[16] = 32'h12345678; ref_mem[16] = 32'h12345678;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_sext = 1'b0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 32'h0; bus.ext_wdata = 32'h0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:cpu_stall", {31'h0, bus.cpu_stall}, 32'h0);
    chk("rst:mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst:mem_we", {28'h0, bus.mem_we}, 32'h0);
    chk("rst:mem_addr", bus.mem_addr, 32'h0);
    chk("rst:mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst:cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst:ext_rdata", bus.ext_rdata, 32'h0);
    chk("rst:ext_ack", {31'h0, bus.ext_ack}, 32'h0);
    chk("rst:err_align", {31'h0, bus.err_align}, 32'h0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    cpu_op("lb_sx", 1'b0, 2'b10, 1'b1, 32'h12, 32'h0, rd, lat);
    chk("lb_sx:const", rd, 32'hFFFFFF81);
    chk("lb_sx:cyc", lat, 4);
    cpu_op("lb_zx", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, lat);
    chk("lb_zx:const", rd, 32'h00000081);
    cpu_op("lh_sx", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, lat);
    chk("lh_sx:const", rd, 32'hFFFF8081);
    cpu_op("sb", 1'b1, 2'b10, 1'b0, 32'h21, 32'h000000AB, rd, lat);
    chk("sb:cyc", lat, 2);
    cpu_op("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, rd, lat);
    cpu_op("sw_mis", 1'b1, 2'b00, 1'b0, 32'h13, 32'hCAFEF00D, rd, lat);
    chk("sw_mis:cyc", lat, 1);
    ext_op("ext_rd", 1'b0, 32'h40, 32'h0, rd, lat);
    chk("ext_rd:const", rd, 32'h12345678);
    chk("ext_rd:cyc", lat, 4);

    // EXT held while the CPU issues six back-to-back word stores.
    begin
      logic [7:0] seq, exp_seq;
      int ng, waited, cpu_done, stall_ack;
      logic ext_done, ext_served, cpu_rel;
      logic [31:0] ext_rd;
      seq = 8'h0; exp_seq = 8'h0; ng = 0; cpu_done = 0; stall_ack = -1;
      ext_done = 1'b0; ext_rd = 32'h0;
      waited = 0; ext_served = 1'b0;
      for (int g = 0; g < 7; g++) begin
        if (!ext_served && waited == STARVE) begin
          exp_seq[g] = 1'b1; ext_served = 1'b1; waited = 0;
        end else if (!ext_served) begin
          waited++;
        end
      end
      ref_mem[32] = 32'h5A5A0001;
      bus.ext_we = 1'b0; bus.ext_addr = 32'h40; bus.ext_req = 1'b1;
      bus.cpu_we = 1'b1; bus.cpu_size = 2'b00; bus.cpu_addr = 32'h80;
      bus.cpu_wdata = 32'h5A5A0001; bus.cpu_req = 1'b1;
      for (int c = 0; c < 200; c++) begin
        if (cpu_done == 6 && ext_done) break;
        @(negedge clk);
        if (bus.mem_en) begin
          if (ng < 8) seq[ng] = (bus.mem_addr == 32'h40);
          ng++;
        end
        if (bus.ext_ack) begin
          ext_done = 1'b1; stall_ack = int'(bus.cpu_stall); ext_rd = bus.ext_rdata;
        end
        cpu_rel = bus.cpu_req && !bus.cpu_stall;
        @(posedge clk); #1;
        if (cpu_rel) begin
          cpu_done++;
          if (cpu_done == 6) bus.cpu_req = 1'b0;
        end
        if (ext_done) bus.ext_req = 1'b0;
      end
      bus.cpu_req = 1'b0; bus.ext_req = 1'b0;
      chk("starve:grants", ng, 7);
      chk("starve:order", {24'h0, seq}, {24'h0, exp_seq});
      chk("starve:stall_at_ack", stall_ack, 1);
      chk("starve:ext_rdata", ext_rd, ref_mem[16]);
      chk("starve:cpu_done", cpu_done, 6);
      chk("starve:cnt_clear", 32'(dut.starve_cnt), 32'h0);
      chk("starve:mem80", mem[32], ref_mem[32]);
    end

    // Reset during WAIT of a CPU read, request kept high across it.
    bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_sext = 1'b0;
    bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_wait:mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst_wait:cpu_stall", {31'h0, bus.cpu_stall}, 32'h0);
    chk("rst_wait:cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_wait:ext_rdata", bus.ext_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_op("rst_rerd", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, lat);
    chk("rst_rerd:const", rd, 32'h80817F01);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      a = $urandom_range(0, 255);
      d = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        ext_op($sformatf("rnd%0d_ext", i), 1'($urandom_range(0, 1)), a, d, rd, lat);
      end else begin
        cpu_op($sformatf("rnd%0d_cpu", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, d, rd, lat);
      end
    end

    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
      end
    end
    chk("final_mem_sample", mem[4], ref_mem[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
